rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 SIZE, 15, highest ROB tag; entries 1..SIZE usable, tag 0 means "none/empty"; storage array is indexed 0..SIZE.
REQ-002 TW = $clog2(SIZE+1), tag width.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 dispatch_en  in  1  dispatch request; dest_reg_idx_in  in  3x5  per-lane dest register; valid_insn_num  in  2  lanes 0..n-1 valid (0-3).
REQ-006 map_table_rob_num  in  3xTW  source tags to look up; dispatch_value_out  out  3x32  looked-up values.
REQ-007 complete_en  in  1; CDB_rob_num  in  3xTW; CDB_value  in  3x32  completion broadcast.
REQ-008 retire_en  in  1; retire_R_out  out  3x5; retire_V_out  out  3x32  retired lanes, oldest in lane 0.
REQ-009 exception_en  in  2  bit0 LSQ, bit1 branch; exception_rob_tag  in  2xTW  tag per exception lane.
REQ-010 clear_all  out  1  flush pulse; head_test, tail_test  out  TW; rob_entry_test  out  (SIZE+1)xROB_ENTRY  debug view.

Function
REQ-011 Entry fields: valid, reg_idx[4:0], reg_val[31:0], complete, exception.
REQ-012 Empty ROB: head=tail=0; otherwise head = oldest tag, tail = youngest tag, tags wrap SIZE->1.
REQ-013 Dispatch (dispatch_en=1): allocate min(valid_insn_num, free) entries after tail, lane order; excess lanes dropped; new entry valid=1, complete=0, exception=0, reg_val=0.
REQ-014 Dispatch into empty ROB sets head=1... i.e. head = first allocated tag; valid_insn_num=0 changes nothing.
REQ-015 Free count = SIZE - occupancy at cycle start (retires this cycle not credited).
REQ-016 Complete (complete_en=1): per lane with nonzero valid tag, set complete=1, reg_val=CDB_value; tag 0 or invalid entry ignored.
REQ-017 Exception: per set exception_en bit with nonzero valid tag, set that entry's exception=1; independent of complete_en.
REQ-018 Retire (retire_en=1): retire k = count of consecutive entries from head with complete=1 and exception=0, max 3; head advances by k; ROB becoming empty sets head=tail=0 (unless same-cycle dispatch).
REQ-019 retire_R_out/V_out combinational: lanes <k show reg_idx/reg_val of retiring entries; other lanes 0.
REQ-020 Flush: retire_en=1 and head entry valid with exception=1 -> clear_all=1 combinationally that cycle; at edge all entries invalidated, head=tail=0; no retire outputs that cycle.
REQ-021 Flush overrides same-cycle dispatch, complete, exception.
REQ-022 dispatch_value_out[i] combinational: CDB_value of matching lane if complete_en and CDB tag equals nonzero map tag; else reg_val if entry valid and complete; else 0.
REQ-023 head_test/tail_test/rob_entry_test reflect registered state.

Reset
REQ-024 reset=0 at edge: head=tail=0, all entry fields 0; clear_all and retire outputs 0 while ROB empty.

Structure
REQ-025 ROB_ENTRY typedef in shared package with field names of REQ-011.
REQ-026 Single module, no sub-modules; occupancy counter kept internally.

Verification (SIZE=8)
REQ-027 Reset; dispatch valid_insn_num=0 -> head=0 tail=0; reset; dispatch 1 (R1) -> head=1 tail=1.
REQ-028 Reset; dispatch 3 (R1-R3), 3 (R4-R6), 3 (R7-R9) -> tail 3, 6, 8; head 1; third accepts only R7,R8.
REQ-029 Complete tags 1,3,5 values 15,16,17; retire -> lane0 R1/15, lanes1-2 zero, head=2.
REQ-030 Dispatch with map_table_rob_num={3,0,0} -> dispatch_value_out[0]=16, others 0; retire freed slot -> tail wraps to 1.
REQ-031 Complete 2,4,6 = 18,19,20 with exception tag 4 (LSQ); retire -> R2/18, R3/16, head=4; next cycle clear_all=1, then head=tail=0.

Source files
------------

// File: rtl/rob_pkg.sv
// Purpose: shared types and lane constants for the reorder buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rob_pkg;

  localparam int LANES = 3;  // dispatch / complete / retire width
  localparam int RW    = 5;  // architectural register index width
  localparam int DW    = 32; // data width

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] reg_idx;
    logic [DW-1:0] reg_val;
    logic          complete;
    logic          exception;
  } ROB_ENTRY;

endpackage

// File: rtl/rob.sv
// Purpose: 3-wide reorder buffer; in-order dispatch/retire, out-of-order completion, flush on exception at head.
// Latency: state updates on the next rising edge; lookup, retire and clear_all outputs are combinational.
// Backpressure: dispatch lanes beyond the free entry count are dropped; retire stops at the first incomplete/excepting entry.
//
// Ports:
//   clk, reset                         - clock, synchronous active-low reset
//   dispatch_en, valid_insn_num,
//   dest_reg_idx_in                    - allocate up to 3 entries after tail
//   map_table_rob_num -> dispatch_value_out - source operand value lookup (with CDB forwarding)
//   complete_en, CDB_rob_num, CDB_value - completion broadcast
//   exception_en, exception_rob_tag    - mark entries as excepting (bit0 LSQ, bit1 branch)
//   retire_en -> retire_R_out/V_out    - retired lanes, oldest in lane 0
//   clear_all                          - flush indication
//   head_test, tail_test, rob_entry_test - debug view of registered state
module rob
  import rob_pkg::*;
#(
  parameter int SIZE = 15,
  localparam int TW = $clog2(SIZE + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dispatch_en,
  input  logic [LANES-1:0][RW-1:0]  dest_reg_idx_in,
  input  logic [1:0]                valid_insn_num,
  input  logic [LANES-1:0][TW-1:0]  map_table_rob_num,
  output logic [LANES-1:0][DW-1:0]  dispatch_value_out,
  input  logic                      complete_en,
  input  logic [LANES-1:0][TW-1:0]  CDB_rob_num,
  input  logic [LANES-1:0][DW-1:0]  CDB_value,
  input  logic                      retire_en,
  output logic [LANES-1:0][RW-1:0]  retire_R_out,
  output logic [LANES-1:0][DW-1:0]  retire_V_out,
  input  logic [1:0]                exception_en,
  input  logic [1:0][TW-1:0]        exception_rob_tag,
  output logic                      clear_all,
  output logic [TW-1:0]             head_test,
  output logic [TW-1:0]             tail_test,
  output ROB_ENTRY [SIZE:0]         rob_entry_test
);

  localparam logic [TW:0]   SIZE_W = (TW+1)'(SIZE);
  localparam logic [TW-1:0] SIZE_T = TW'(SIZE);

  ROB_ENTRY [SIZE:0] entries;
  logic [TW-1:0]     head, tail, count;

  logic [TW-1:0]            free_cnt, cnt_n, head_n, tail_n;
  logic [1:0]               n_alloc, ret_k;
  logic                     flush, stop;
  logic [LANES-1:0][TW-1:0] ret_tag;

  // Tag arithmetic on the 1..SIZE ring; t=0 (empty) advances to tag n.
  function automatic logic [TW-1:0] nxt(input logic [TW-1:0] t, input logic [1:0] n);
    logic [TW:0] s;
    s = {1'b0, t} + (TW+1)'(n);
    if (s > SIZE_W) s = s - SIZE_W;
    return s[TW-1:0];
  endfunction

  function automatic logic tag_ok(input logic [TW-1:0] t);
    return (t != '0) && ({1'b0, t} <= SIZE_W);
  endfunction

  // Allocation is limited by occupancy at cycle start; same-cycle retires do not free space.
  always_comb begin
    free_cnt = SIZE_T - count;
    n_alloc  = 2'd0;
    if (dispatch_en) begin
      if (TW'(valid_insn_num) <= free_cnt) n_alloc = valid_insn_num;
      else                                  n_alloc = free_cnt[1:0];
    end
  end

  // Retire count: consecutive completed, non-excepting entries from head.
  always_comb begin
    flush = retire_en && entries[head].valid && entries[head].exception;
    ret_k = 2'd0;
    stop  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      ret_tag[i] = nxt(head, 2'(i));
      if (!stop && retire_en && !flush && (TW'(i) < count) &&
          entries[ret_tag[i]].valid && entries[ret_tag[i]].complete &&
          !entries[ret_tag[i]].exception)
        ret_k = ret_k + 2'd1;
      else
        stop = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      retire_R_out[i] = '0;
      retire_V_out[i] = '0;
      if (2'(i) < ret_k) begin
        retire_R_out[i] = entries[ret_tag[i]].reg_idx;
        retire_V_out[i] = entries[ret_tag[i]].reg_val;
      end
    end
  end

  // Operand lookup: a same-cycle CDB broadcast wins over the stored value.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      dispatch_value_out[i] = '0;
      if (tag_ok(map_table_rob_num[i]) && entries[map_table_rob_num[i]].valid &&
          entries[map_table_rob_num[i]].complete)
        dispatch_value_out[i] = entries[map_table_rob_num[i]].reg_val;
      if (map_table_rob_num[i] != '0) begin
        for (int j = 0; j < LANES; j++) begin
          if (complete_en && (CDB_rob_num[j] == map_table_rob_num[i]))
            dispatch_value_out[i] = CDB_value[j];
        end
      end
    end
  end

  // Next pointers; an empty result always parks head/tail at 0 so the next dispatch starts at tag 1.
  always_comb begin
    cnt_n  = count - TW'(ret_k) + TW'(n_alloc);
    head_n = '0;
    tail_n = '0;
    if (cnt_n != '0) begin
      tail_n = nxt(tail, n_alloc);
      head_n = (count == '0) ? nxt(tail, 2'd1) : nxt(head, ret_k);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      entries <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else if (flush) begin
      entries <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      for (int j = 0; j < LANES; j++) begin
        if (complete_en && tag_ok(CDB_rob_num[j]) && entries[CDB_rob_num[j]].valid) begin
          entries[CDB_rob_num[j]].complete <= 1'b1;
          entries[CDB_rob_num[j]].reg_val  <= CDB_value[j];
        end
      end
      for (int e = 0; e < 2; e++) begin
        if (exception_en[e] && tag_ok(exception_rob_tag[e]) && entries[exception_rob_tag[e]].valid)
          entries[exception_rob_tag[e]].exception <= 1'b1;
      end
      for (int i = 0; i < LANES; i++) begin
        if (2'(i) < ret_k) entries[ret_tag[i]] <= '0;
      end
      // Slots written here were free at cycle start, so they never collide with the writes above.
      for (int i = 0; i < LANES; i++) begin
        if (2'(i) < n_alloc)
          entries[nxt(tail, 2'(i + 1))] <= '{valid: 1'b1, reg_idx: dest_reg_idx_in[i],
                                             reg_val: '0, complete: 1'b0, exception: 1'b0};
      end
      head  <= head_n;
      tail  <= tail_n;
      count <= cnt_n;
    end
  end

  assign clear_all      = flush;
  assign head_test      = head;
  assign tail_test      = tail;
  assign rob_entry_test = entries;

endmodule

// File: tb/tb_rob.sv
// Purpose: self-checking bench for rob (SIZE=8); expected retirements are queued as stimulus is driven.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled before the next edge.
// Backpressure: exercises full-ROB dispatch drop and retire stalls on incomplete/excepting entries.
module tb_rob;
  import rob_pkg::*;

  localparam int SIZE = 8;
  localparam int TW   = $clog2(SIZE + 1);

  logic                 clk, reset, dispatch_en, complete_en, retire_en, clear_all;
  logic [2:0][4:0]      dest_reg_idx_in, retire_R_out;
  logic [1:0]           valid_insn_num, exception_en;
  logic [2:0][TW-1:0]   map_table_rob_num, CDB_rob_num;
  logic [2:0][31:0]     dispatch_value_out, CDB_value, retire_V_out;
  logic [1:0][TW-1:0]   exception_rob_tag;
  logic [TW-1:0]        head_test, tail_test;
  ROB_ENTRY [SIZE:0]    rob_entry_test;

  rob #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .dispatch_en(dispatch_en), .dest_reg_idx_in(dest_reg_idx_in),
    .valid_insn_num(valid_insn_num), .map_table_rob_num(map_table_rob_num),
    .dispatch_value_out(dispatch_value_out), .complete_en(complete_en), .CDB_rob_num(CDB_rob_num),
    .CDB_value(CDB_value), .retire_en(retire_en), .retire_R_out(retire_R_out),
    .retire_V_out(retire_V_out), .exception_en(exception_en), .exception_rob_tag(exception_rob_tag),
    .clear_all(clear_all), .head_test(head_test), .tail_test(tail_test),
    .rob_entry_test(rob_entry_test)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [36:0] exp_q[$];  // {reg_idx, reg_val} in retirement order

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle();
    dispatch_en = 1'b0; valid_insn_num = '0; dest_reg_idx_in = '0;
    map_table_rob_num = '0; complete_en = 1'b0; CDB_rob_num = '0; CDB_value = '0;
    retire_en = 1'b0; exception_en = '0; exception_rob_tag = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic dispatch(input logic [1:0] n, input logic [4:0] r0, input logic [4:0] r1,
                          input logic [4:0] r2);
    dispatch_en = 1'b1;
    valid_insn_num = n;
    dest_reg_idx_in[0] = r0; dest_reg_idx_in[1] = r1; dest_reg_idx_in[2] = r2;
  endtask

  task automatic complete3(input logic [TW-1:0] t0, input logic [31:0] v0,
                           input logic [TW-1:0] t1, input logic [31:0] v1,
                           input logic [TW-1:0] t2, input logic [31:0] v2);
    complete_en = 1'b1;
    CDB_rob_num[0] = t0; CDB_value[0] = v0;
    CDB_rob_num[1] = t1; CDB_value[1] = v1;
    CDB_rob_num[2] = t2; CDB_value[2] = v2;
  endtask

  // Every nonzero retire lane must match the next queued expectation.
  task automatic check_retire();
    logic [36:0] e;
    for (int i = 0; i < 3; i++) begin
      if (retire_R_out[i] != '0 || retire_V_out[i] != '0) begin
        if (exp_q.size() == 0) chk("ret_unexpected", {retire_R_out[i], retire_V_out[i]}, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("ret_lane", {retire_R_out[i], retire_V_out[i]}, e);
        end
      end
    end
    chk("ret_drained", exp_q.size(), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    tick(); tick();
    reset = 1'b1;
    chk("rst_head", head_test, 0);
    chk("rst_tail", tail_test, 0);
    chk("rst_entries_zero", rob_entry_test == '0, 1);
    chk("rst_clear_all", clear_all, 0);
    chk("rst_retire_R", retire_R_out, 0);

    // zero-lane dispatch changes nothing
    dispatch(2'd0, 5'd1, 5'd2, 5'd3);
    tick();
    chk("disp0_head", head_test, 0);
    chk("disp0_tail", tail_test, 0);

    do_reset();
    dispatch(2'd1, 5'd1, 5'd0, 5'd0);
    tick();
    chk("disp1_head", head_test, 1);
    chk("disp1_tail", tail_test, 1);
    chk("disp1_valid", rob_entry_test[1].valid, 1);
    chk("disp1_reg", rob_entry_test[1].reg_idx, 1);

    // fill: 3 + 3 + (3 requested, 2 fit)
    do_reset();
    dispatch(2'd3, 5'd1, 5'd2, 5'd3);
    tick();
    chk("fill_tail3", tail_test, 3);
    dispatch(2'd3, 5'd4, 5'd5, 5'd6);
    retire_en = 1'b1;  // nothing complete: no retire
    settle();
    chk("noret_R", retire_R_out, 0);
    chk("noret_V", retire_V_out, 0);
    tick();
    chk("fill_tail6", tail_test, 6);
    dispatch(2'd3, 5'd7, 5'd8, 5'd9);
    tick();
    chk("fill_tail8", tail_test, 8);
    chk("fill_head", head_test, 1);
    chk("fill_r8", rob_entry_test[8].reg_idx, 8);
    chk("fill_cmp8", rob_entry_test[8].complete, 0);
    chk("fill_r0_untouched", rob_entry_test[0].valid, 0);

    // complete 1,3,5 with CDB forwarding on the lookup port
    complete3(4'd1, 32'd15, 4'd3, 32'd16, 4'd5, 32'd17);
    map_table_rob_num[0] = 4'd3;
    map_table_rob_num[1] = 4'd7;
    settle();
    chk("fwd_cdb", dispatch_value_out[0], 16);
    chk("fwd_incomplete", dispatch_value_out[1], 0);
    tick();
    chk("cmp3_val", rob_entry_test[3].reg_val, 16);

    retire_en = 1'b1;
    exp_q.push_back({5'd1, 32'd15});
    settle();
    check_retire();
    chk("ret1_lane1", {retire_R_out[1], retire_V_out[1]}, 0);
    chk("ret1_lane2", {retire_R_out[2], retire_V_out[2]}, 0);
    tick();
    chk("ret1_head", head_test, 2);

    // lookup from stored value while dispatching into the freed slot; tail wraps
    dispatch(2'd1, 5'd10, 5'd0, 5'd0);
    map_table_rob_num[0] = 4'd3;
    settle();
    chk("lookup0", dispatch_value_out[0], 16);
    chk("lookup1", dispatch_value_out[1], 0);
    chk("lookup2", dispatch_value_out[2], 0);
    tick();
    chk("wrap_tail", tail_test, 1);
    chk("wrap_reg", rob_entry_test[1].reg_idx, 10);
    dispatch(2'd3, 5'd11, 5'd12, 5'd13);  // full: dropped
    tick();
    chk("full_tail", tail_test, 1);
    chk("full_head", head_test, 2);

    // complete 2,4,6 with an LSQ exception on tag 4
    complete3(4'd2, 32'd18, 4'd4, 32'd19, 4'd6, 32'd20);
    exception_en = 2'b01;
    exception_rob_tag[0] = 4'd4;
    tick();
    chk("exc4_flag", rob_entry_test[4].exception, 1);
    chk("exc4_val", rob_entry_test[4].reg_val, 19);

    retire_en = 1'b1;
    exp_q.push_back({5'd2, 32'd18});
    exp_q.push_back({5'd3, 32'd16});
    settle();
    check_retire();
    chk("ret2_clear", clear_all, 0);
    chk("ret2_lane2", {retire_R_out[2], retire_V_out[2]}, 0);
    tick();
    chk("ret2_head", head_test, 4);

    // flush at head, overriding a same-cycle dispatch
    retire_en = 1'b1;
    dispatch(2'd1, 5'd20, 5'd0, 5'd0);
    settle();
    chk("flush_clear", clear_all, 1);
    chk("flush_noret", retire_R_out, 0);
    tick();
    chk("flush_head", head_test, 0);
    chk("flush_tail", tail_test, 0);
    chk("flush_entries", rob_entry_test == '0, 1);
    chk("flush_clear_low", clear_all, 0);

    // restart at tag 1; tag 0 on CDB ignored; retire blocked until head completes; drain to empty
    dispatch(2'd2, 5'd21, 5'd22, 5'd0);
    tick();
    chk("re_head", head_test, 1);
    chk("re_tail", tail_test, 2);
    complete3(4'd0, 32'd99, 4'd2, 32'd33, 4'd0, 32'd98);
    tick();
    chk("tag0_ignored", rob_entry_test[0].valid, 0);
    retire_en = 1'b1;
    settle();
    chk("blocked_R", retire_R_out, 0);
    tick();
    complete3(4'd1, 32'd44, 4'd0, 32'd0, 4'd0, 32'd0);
    tick();
    retire_en = 1'b1;
    exp_q.push_back({5'd21, 32'd44});
    exp_q.push_back({5'd22, 32'd33});
    settle();
    check_retire();
    tick();
    chk("empty_head", head_test, 0);
    chk("empty_tail", tail_test, 0);
    chk("empty_valid2", rob_entry_test[2].valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
